// File: rtl/irda_mir_rx_framer_pkg.sv
// Shared definitions for the MIR receive framer: FSM states, CRC constants
// and the serial CRC-CCITT16 step function.
package irda_mir_rx_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STA  = 2'd1,
    ST_DATA = 2'd2,
    ST_CHK  = 2'd3
  } rx_state_t;

  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;
  localparam logic [15:0] CRC_POLY    = 16'h1021;

  // Bit periods absorbed after a flag before data may start
  localparam logic [2:0] FLAG_CNT_RELOAD = 3'd7;

  // One serial step of x^16+x^12+x^5+1, bits fed in arrival order
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/irda_mir_rx_framer_crc16_ser.sv
// Serial CRC-CCITT16 accumulator with synchronous clear and per-bit enable.
module irda_mir_rx_framer_crc16_ser
  import irda_mir_rx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        wb_rst_i,
  input  logic        clr,
  input  logic        bit_en,
  input  logic        din,
  output logic [15:0] crc
);

  // CRC register: restarts at all ones, advances one step per enabled bit
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (bit_en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/irda_mir_rx_framer.sv
// MIR receive framer: absorbs opening flags, packs de-stuffed bits into
// FIFO words (first bit in bit 0), counts bytes, checks the CRC residue and
// reports per-frame status. Aborts on break or length overrun.
module irda_mir_rx_framer
  import irda_mir_rx_framer_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          LEN_W     = 16,
  parameter int unsigned MAX_BYTES = 2051,
  parameter int unsigned MIN_BYTES = 3
) (
  input  logic                      clk,
  input  logic                      wb_rst_i,
  input  logic                      rx_restart,
  input  logic                      bit_en,
  input  logic                      flag_det,
  input  logic                      brk_det,
  input  logic                      dbit_vld,
  input  logic                      dbit,
  input  logic                      fifo_full,
  output logic [DATA_W-1:0]         rxf_dat,
  output logic                      rxf_push,
  output logic                      rxf_last,
  output logic [$clog2(DATA_W/8):0] rxf_nbytes,
  output logic [LEN_W-1:0]          frame_len,
  output logic                      frame_done,
  output logic                      crc_err,
  output logic                      align_err,
  output logic                      len_err,
  output logic                      overrun_err,
  output logic                      abort_err,
  output logic                      busy
);

  localparam int PTR_W = $clog2(DATA_W);
  localparam int NB_W  = $clog2(DATA_W / 8) + 1;

  rx_state_t         state, state_n;
  logic [2:0]        flag_cnt, flag_cnt_n;
  logic [PTR_W-1:0]  ptr, ptr_n;
  logic [DATA_W-1:0] word, word_n, word_ins;
  logic [PTR_W:0]    ptr_ext;
  logic [NB_W-1:0]   held_bytes;
  logic              byte_done;
  logic [LEN_W-1:0]  frame_len_n;
  logic [DATA_W-1:0] dat_n;
  logic              last_n;
  logic [NB_W-1:0]   nbytes_n;
  logic              push_req, push_n, done_n;
  logic              crc_err_n, align_err_n, len_err_n, overrun_err_n, abort_err_n;
  logic              crc_clr, crc_en;
  logic [15:0]       crc;

  irda_mir_rx_framer_crc16_ser u_crc (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .clr      (crc_clr),
    .bit_en   (crc_en),
    .din      (dbit),
    .crc      (crc)
  );

  // Whole or partial bytes held in the packer, and the current byte finishing
  assign ptr_ext    = {1'b0, ptr} + (PTR_W + 1)'(7);
  assign held_bytes = ptr_ext[PTR_W:3];
  assign byte_done  = (ptr[2:0] == 3'd7);
  assign busy       = (state != ST_IDLE);

  // Packer word with the incoming bit placed at the pointer
  always_comb begin
    word_ins      = word;
    word_ins[ptr] = dbit;
  end

  // Next-state, packer, counter and status logic
  always_comb begin
    state_n       = state;
    flag_cnt_n    = flag_cnt;
    ptr_n         = ptr;
    word_n        = word;
    frame_len_n   = frame_len;
    dat_n         = rxf_dat;
    last_n        = rxf_last;
    nbytes_n      = rxf_nbytes;
    push_req      = 1'b0;
    done_n        = 1'b0;
    crc_err_n     = crc_err;
    align_err_n   = align_err;
    len_err_n     = len_err;
    overrun_err_n = overrun_err;
    abort_err_n   = abort_err;
    crc_clr       = 1'b0;
    crc_en        = 1'b0;

    if (rx_restart) begin
      state_n       = ST_IDLE;
      flag_cnt_n    = '0;
      ptr_n         = '0;
      word_n        = '0;
      frame_len_n   = '0;
      crc_err_n     = 1'b0;
      align_err_n   = 1'b0;
      len_err_n     = 1'b0;
      overrun_err_n = 1'b0;
      abort_err_n   = 1'b0;
      crc_clr       = 1'b1;
    end else if (bit_en) begin
      case (state)
        ST_IDLE: begin
          if (flag_det) begin
            state_n       = ST_STA;
            flag_cnt_n    = FLAG_CNT_RELOAD;
            ptr_n         = '0;
            word_n        = '0;
            frame_len_n   = '0;
            crc_err_n     = 1'b0;
            align_err_n   = 1'b0;
            len_err_n     = 1'b0;
            overrun_err_n = 1'b0;
            abort_err_n   = 1'b0;
            crc_clr       = 1'b1;
          end
        end
        ST_STA: begin
          if (brk_det) begin
            abort_err_n = 1'b1;
            done_n      = 1'b1;
            state_n     = ST_IDLE;
          end else if (flag_cnt != 3'd0) begin
            flag_cnt_n = flag_cnt - 3'd1;
          end else if (flag_det) begin
            flag_cnt_n = FLAG_CNT_RELOAD;
          end else begin
            state_n = ST_DATA;
          end
        end
        ST_DATA: begin
          if (brk_det) begin
            abort_err_n = 1'b1;
            if (ptr != '0) begin
              push_req = 1'b1;
              dat_n    = word;
              last_n   = 1'b1;
              nbytes_n = held_bytes;
            end
            done_n  = 1'b1;
            state_n = ST_IDLE;
            ptr_n   = '0;
            word_n  = '0;
          end else if (flag_det) begin
            if (ptr[2:0] != 3'd0) begin
              align_err_n = 1'b1;
            end
            push_req = 1'b1;
            dat_n    = word;
            last_n   = 1'b1;
            nbytes_n = held_bytes;
            ptr_n    = '0;
            word_n   = '0;
            state_n  = ST_CHK;
          end else if (dbit_vld) begin
            if (byte_done && (32'(frame_len) >= MAX_BYTES)) begin
              len_err_n = 1'b1;
              if (ptr != '0) begin
                push_req = 1'b1;
                dat_n    = word;
                last_n   = 1'b1;
                nbytes_n = held_bytes;
              end
              done_n  = 1'b1;
              state_n = ST_IDLE;
              ptr_n   = '0;
              word_n  = '0;
            end else begin
              crc_en = 1'b1;
              if (byte_done && (frame_len != '1)) begin
                frame_len_n = frame_len + LEN_W'(1);
              end
              if (ptr == PTR_W'(DATA_W - 1)) begin
                push_req = 1'b1;
                dat_n    = word_ins;
                last_n   = 1'b0;
                nbytes_n = NB_W'(DATA_W / 8);
                ptr_n    = '0;
                word_n   = '0;
              end else begin
                word_n = word_ins;
                ptr_n  = ptr + PTR_W'(1);
              end
            end
          end
        end
        ST_CHK: begin
          if (brk_det) begin
            abort_err_n = 1'b1;
          end else begin
            crc_err_n = (crc != CRC_RESIDUE);
            if (32'(frame_len) < MIN_BYTES) begin
              len_err_n = 1'b1;
            end
          end
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end

    push_n = push_req & ~fifo_full;
    if (push_req && fifo_full) begin
      overrun_err_n = 1'b1;
    end
  end

  // State, packer, counters and registered outputs
  always_ff @(posedge clk or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state       <= ST_IDLE;
      flag_cnt    <= '0;
      ptr         <= '0;
      word        <= '0;
      frame_len   <= '0;
      rxf_dat     <= '0;
      rxf_push    <= 1'b0;
      rxf_last    <= 1'b0;
      rxf_nbytes  <= '0;
      frame_done  <= 1'b0;
      crc_err     <= 1'b0;
      align_err   <= 1'b0;
      len_err     <= 1'b0;
      overrun_err <= 1'b0;
      abort_err   <= 1'b0;
    end else begin
      state       <= state_n;
      flag_cnt    <= flag_cnt_n;
      ptr         <= ptr_n;
      word        <= word_n;
      frame_len   <= frame_len_n;
      rxf_dat     <= dat_n;
      rxf_push    <= push_n;
      rxf_last    <= last_n;
      rxf_nbytes  <= nbytes_n;
      frame_done  <= done_n;
      crc_err     <= crc_err_n;
      align_err   <= align_err_n;
      len_err     <= len_err_n;
      overrun_err <= overrun_err_n;
      abort_err   <= abort_err_n;
    end
  end

endmodule
